thermo_ctrl_fsm: RTL and testbench

//  Thermostat control stage directly downstream of the midterm input-register bank.

---
 rtl/thermo_ctrl_fsm_if.sv | 37 +++
 rtl/thermo_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_thermo_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/thermo_ctrl_fsm_if.sv
// Signal bundle between the input-register bank and the thermostat controller.
// Optional macro THERMO_ALARM_EN adds the over-temperature alarm output.
// Handshake: there is no valid/ready pair. Every input is a level sampled on
// each rising clk edge, and every output is a registered level that is valid
// for the whole following cycle.
interface thermo_ctrl_fsm_if;
    logic [3:0] temp_in;
    logic [1:0] meas_in;
    logic       ld_in;
    logic       st_in;
    logic       heat_out;
    logic       cool_out;
    logic       fan_out;
    logic [1:0] state_out;
    logic [3:0] sp_out;
`ifdef THERMO_ALARM_EN
    logic       alarm_out;
`endif

    // Driver side (register bank / testbench)
    modport master (
        output temp_in, meas_in, ld_in, st_in,
`ifdef THERMO_ALARM_EN
        input  alarm_out,
`endif
        input  heat_out, cool_out, fan_out, state_out, sp_out
    );

    // Controller side
    modport slave (
        input  temp_in, meas_in, ld_in, st_in,
`ifdef THERMO_ALARM_EN
        output alarm_out,
`endif
        output heat_out, cool_out, fan_out, state_out, sp_out
    );
endinterface

// File: rtl/thermo_ctrl_fsm.sv
// Thermostat control stage: loadable setpoint, hysteresis FSM driving
// heat/cool/fan, with minimum run and rest times to prevent short-cycling.
// Optional macro THERMO_ALARM_EN: sticky over-temperature alarm that blocks
// heating and forces an active HEAT run into REST.
module thermo_ctrl_fsm #(
    parameter int HYST     = 1,
    parameter int MIN_RUN  = 4,
    parameter int MIN_REST = 2,
    parameter int SP_RESET = 8
) (
    input  logic              clk,
    input  logic              clr,
    thermo_ctrl_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_REST = 2'b11
    } state_t;

    // Counter only needs to reach the larger of the two timing limits.
    localparam int CNT_MAX = (MIN_RUN > MIN_REST) ? MIN_RUN : MIN_REST;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(MIN_REST - 1);
    localparam logic [4:0]       HYST_V    = 5'(HYST);
    localparam logic [3:0]       SP_INIT   = 4'(SP_RESET);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sp_q, sp_d;

    logic [4:0] sp_ext, lo_raw, hi_raw;
    logic [3:0] lo, hi;
    logic       heat_req, cool_req;
    logic       heat_abort, cool_abort;
    logic       alarm_block;

`ifdef THERMO_ALARM_EN
    logic alarm_q, alarm_d;
`endif

    // Hysteresis band around the registered setpoint, computed in 5 bits and clamped to 0..15
    always_comb begin
        sp_ext = {1'b0, sp_q};
        lo_raw = sp_ext - HYST_V;
        hi_raw = sp_ext + HYST_V;
        lo     = lo_raw[4] ? 4'd0 : lo_raw[3:0];
        hi     = (hi_raw > 5'd15) ? 4'hF : hi_raw[3:0];
    end

`ifdef THERMO_ALARM_EN
    assign alarm_block = alarm_q;
`else
    assign alarm_block = 1'b0;
`endif

    assign heat_req   = bus.st_in & bus.meas_in[0] & (bus.temp_in < lo) & ~alarm_block;
    assign cool_req   = bus.st_in & bus.meas_in[1] & (bus.temp_in > hi);
    assign heat_abort = ~bus.st_in | ~bus.meas_in[0] | alarm_block;
    assign cool_abort = ~bus.st_in | ~bus.meas_in[1];

    // Setpoint load and sticky alarm next-state
    always_comb begin
        sp_d = sp_q;
        if (bus.ld_in) begin
            sp_d = bus.temp_in;
        end
`ifdef THERMO_ALARM_EN
        alarm_d = alarm_q;
        if (bus.temp_in == 4'hF) begin
            alarm_d = 1'b1;
        end else if (bus.ld_in) begin
            alarm_d = 1'b0;
        end
`endif
    end

    // Next state and dwell counter; counter restarts at 0 on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (heat_req) begin
                    state_d = ST_HEAT;
                end else if (cool_req) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (heat_abort) begin
                    state_d = ST_REST;
                end else if ((cnt_q >= RUN_LAST) && (bus.temp_in >= sp_q)) begin
                    state_d = ST_REST;
                end
            end
            ST_COOL: begin
                if (cool_abort) begin
                    state_d = ST_REST;
                end else if ((cnt_q >= RUN_LAST) && (bus.temp_in <= sp_q)) begin
                    state_d = ST_REST;
                end
            end
            ST_REST: begin
                if (cnt_q == REST_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != ST_IDLE) && (cnt_q < CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, counter and setpoint registers; clr acts immediately
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sp_q    <= SP_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
        end
    end

`ifdef THERMO_ALARM_EN
    // Alarm register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.alarm_out = alarm_q;
`endif

    // Outputs decode straight from the state register
    assign bus.heat_out  = (state_q == ST_HEAT);
    assign bus.cool_out  = (state_q == ST_COOL);
    assign bus.fan_out   = (state_q != ST_IDLE);
    assign bus.state_out = state_q;
    assign bus.sp_out    = sp_q;

endmodule

// File: tb/tb_thermo_ctrl_fsm.sv
// Bench for thermo_ctrl_fsm (HYST=1, MIN_RUN=4, MIN_REST=2, SP_RESET=8).
// Honours THERMO_ALARM_EN when it is defined for the build.
module tb_thermo_ctrl_fsm;

    localparam int HYST     = 1;
    localparam int MIN_RUN  = 4;
    localparam int MIN_REST = 2;
    localparam int SP_RESET = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    thermo_ctrl_fsm_if dut_if ();

    thermo_ctrl_fsm #(
        .HYST(HYST), .MIN_RUN(MIN_RUN), .MIN_REST(MIN_REST), .SP_RESET(SP_RESET)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (dut_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 heat, 2 cool, 3 rest; age = cycles since entering the mode.
    int m_mode;
    int m_age;
    int m_sp;
    bit m_alarm;

    function automatic void model_reset();
        m_mode  = 0;
        m_age   = 0;
        m_sp    = SP_RESET;
        m_alarm = 1'b0;
    endfunction

    function automatic void model_step(input bit ld, input bit st, input bit [1:0] meas, input int temp);
        int lo, hi, nxt;
        bit hreq, creq, blocked;
        lo = (m_sp - HYST < 0) ? 0 : m_sp - HYST;
        hi = (m_sp + HYST > 15) ? 15 : m_sp + HYST;
        blocked = 1'b0;
`ifdef THERMO_ALARM_EN
        blocked = m_alarm;
`endif
        hreq = st && meas[0] && (temp < lo) && !blocked;
        creq = st && meas[1] && (temp > hi);
        nxt  = m_mode;
        if (m_mode == 0) begin
            if (hreq) nxt = 1;
            else if (creq) nxt = 2;
        end else if (m_mode == 1) begin
            if (!st || !meas[0] || blocked) nxt = 3;
            else if (m_age + 1 >= MIN_RUN && temp >= m_sp) nxt = 3;
        end else if (m_mode == 2) begin
            if (!st || !meas[1]) nxt = 3;
            else if (m_age + 1 >= MIN_RUN && temp <= m_sp) nxt = 3;
        end else begin
            if (m_age + 1 == MIN_REST) nxt = 0;
        end
        m_age  = (nxt != m_mode) ? 0 : m_age + 1;
        m_mode = nxt;
        if (ld) m_sp = temp;
        if (temp == 15) m_alarm = 1'b1;
        else if (ld) m_alarm = 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ld, input bit st, input bit [1:0] meas, input int temp);
        dut_if.ld_in   = ld;
        dut_if.st_in   = st;
        dut_if.meas_in = meas;
        dut_if.temp_in = 4'(temp);
    endtask

    // One clock: inputs are already stable; model follows the edge; outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_step(dut_if.ld_in, dut_if.st_in, dut_if.meas_in, int'(dut_if.temp_in));
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int exp_state, input int exp_sp);
        bit ok;
        bit eh, ec, ef;
        eh = (exp_state == 1);
        ec = (exp_state == 2);
        ef = (exp_state != 0);
        n_vec++;
        ok = (dut_if.state_out === 2'(exp_state)) && (dut_if.sp_out === 4'(exp_sp)) &&
             (dut_if.heat_out === eh) && (dut_if.cool_out === ec) && (dut_if.fan_out === ef);
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got state=%0d sp=%0d heat=%0b cool=%0b fan=%0b, want state=%0d sp=%0d heat=%0b cool=%0b fan=%0b",
                     name, dut_if.state_out, dut_if.sp_out, dut_if.heat_out, dut_if.cool_out,
                     dut_if.fan_out, exp_state, exp_sp, eh, ec, ef);
        end
    endtask

`ifdef THERMO_ALARM_EN
    task automatic check_alarm(input string name, input bit exp_alarm);
        n_vec++;
        if (dut_if.alarm_out !== exp_alarm) begin
            n_err++;
            $display("FAIL %s: got alarm=%0b, want alarm=%0b", name, dut_if.alarm_out, exp_alarm);
        end
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        bit       ld;
        bit       st;
        bit [1:0] meas;
        int       temp;
        int       exp_state;
        int       exp_sp;
    } vec_t;

    vec_t tbl[27];

    initial begin
        // load + heat run, then rest, then idle
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 10, 0, 10};
        tbl[1]  = '{1'b0, 1'b1, 2'b01,  8, 1, 10};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 10, 1, 10};
        tbl[3]  = '{1'b0, 1'b1, 2'b01, 10, 1, 10};
        tbl[4]  = '{1'b0, 1'b1, 2'b01, 10, 1, 10};
        tbl[5]  = '{1'b0, 1'b1, 2'b01, 10, 3, 10};
        tbl[6]  = '{1'b0, 1'b1, 2'b01, 10, 3, 10};
        tbl[7]  = '{1'b0, 1'b1, 2'b01, 10, 0, 10};
        tbl[8]  = '{1'b0, 1'b1, 2'b01, 10, 0, 10};
        // cool band at sp=5
        tbl[9]  = '{1'b1, 1'b1, 2'b10,  5, 0,  5};
        tbl[10] = '{1'b0, 1'b1, 2'b10,  6, 0,  5};
        tbl[11] = '{1'b0, 1'b1, 2'b10,  7, 2,  5};
        tbl[12] = '{1'b0, 1'b1, 2'b10,  7, 2,  5};
        tbl[13] = '{1'b0, 1'b1, 2'b10,  5, 2,  5};
        tbl[14] = '{1'b0, 1'b1, 2'b10,  5, 2,  5};
        tbl[15] = '{1'b0, 1'b1, 2'b10,  5, 3,  5};
        tbl[16] = '{1'b0, 1'b1, 2'b10,  5, 3,  5};
        tbl[17] = '{1'b0, 1'b1, 2'b10,  5, 0,  5};
        // clamped bands: sp=0 and sp=15 never leave IDLE
        tbl[18] = '{1'b1, 1'b0, 2'b11,  0, 0,  0};
        tbl[19] = '{1'b0, 1'b1, 2'b11,  0, 0,  0};
        tbl[20] = '{1'b0, 1'b1, 2'b11,  0, 0,  0};
        tbl[21] = '{1'b0, 1'b1, 2'b11,  1, 0,  0};
        tbl[22] = '{1'b1, 1'b0, 2'b11, 15, 0, 15};
        tbl[23] = '{1'b0, 1'b1, 2'b11, 15, 0, 15};
        tbl[24] = '{1'b0, 1'b1, 2'b11, 15, 0, 15};
        tbl[25] = '{1'b0, 1'b1, 2'b11, 14, 0, 15};
        tbl[26] = '{1'b0, 1'b1, 2'b11, 14, 0, 15};
    end

    // ---------------- test sequence ----------------
    initial begin
        clr = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", 0, SP_RESET);
        clr = 1'b0;

        // asynchronous clear in the middle of a HEAT run, with a non-default setpoint
        drive(1'b1, 1'b0, 2'b00, 12);
        tick();
        check("t1_load", 0, 12);
        drive(1'b0, 1'b1, 2'b01, 3);
        tick();
        check("t1_heat", 1, 12);
        #2;
        clr = 1'b1;
        #1;
        check("t1_async_clr", 0, SP_RESET);
        model_reset();
        drive(1'b0, 1'b0, 2'b00, 0);
        @(negedge clk);
        check("t1_clr_held", 0, SP_RESET);
        clr = 1'b0;

        // table vectors
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].ld, tbl[i].st, tbl[i].meas, tbl[i].temp);
            tick();
            check($sformatf("tbl[%0d]", i), tbl[i].exp_state, tbl[i].exp_sp);
        end

        // abort: drop st_in at counter=1 of HEAT
        drive(1'b1, 1'b0, 2'b00, 8);
        tick();
        check("t4_load", 0, 8);
        drive(1'b0, 1'b1, 2'b01, 5);
        tick();
        check("t4_heat0", 1, 8);
        tick();
        check("t4_heat1", 1, 8);
        drive(1'b0, 1'b0, 2'b01, 5);
        tick();
        check("t4_rest0", 3, 8);
        tick();
        check("t4_rest1", 3, 8);
        tick();
        check("t4_idle", 0, 8);

`ifdef THERMO_ALARM_EN
        // alarm: over-temperature during HEAT forces REST, ld clears it
        drive(1'b0, 1'b1, 2'b01, 5);
        tick();
        check("t6_heat", 1, 8);
        drive(1'b0, 1'b1, 2'b01, 15);
        tick();
        check("t6_heat_hot", 1, 8);
        check_alarm("t6_alarm_set", 1'b1);
        tick();
        check("t6_rest", 3, 8);
        drive(1'b1, 1'b0, 2'b00, 9);
        tick();
        check("t6_clear", 3, 9);
        check_alarm("t6_alarm_clr", 1'b0);
        tick();
        check("t6_idle", 0, 9);
`endif

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2;
                clr = 1'b1;
                #1;
                model_reset();
                check("rnd_clr", m_mode, m_sp);
                @(negedge clk);
                clr = 1'b0;
            end
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            tick();
            check($sformatf("rnd[%0d]", n), m_mode, m_sp);
`ifdef THERMO_ALARM_EN
            check_alarm($sformatf("rnd_alarm[%0d]", n), m_alarm);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
